// File: rtl/i_cache_pkg.sv
// i_cache_pkg
//   Shared types and helpers for the set-associative instruction cache
//   controller.
//   - icache_state_t : controller FSM state encoding
//   - DEF_*          : default geometry (2 ways, 4-word lines, 16 sets)
//   - clog2_min1     : $clog2 that never returns 0, for index fields
//   - WAY_W / BEAT_W / SET_W : index widths for the default geometry
package i_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FLUSH  = 2'd3
  } icache_state_t;

  localparam int DEF_WAYS       = 2;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_SETS       = 16;

  // A one-word line still needs a 1-bit beat field, so widths bottom out at 1.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int WAY_W  = clog2_min1(DEF_WAYS);
  localparam int BEAT_W = clog2_min1(DEF_LINE_WORDS);
  localparam int SET_W  = clog2_min1(DEF_SETS);

endpackage

// File: rtl/i_cache_assoc_control_victim_sel.sv
// i_cache_victim_sel
//   Victim selection for a miss, plus the per-set round-robin pointers.
//   The lowest-index invalid way wins; only a full set falls back to the
//   set's round-robin pointer.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     lookup_set       set being looked up this cycle
//     way_valid        valid bits of lookup_set
//     adv_en, adv_set  advance the pointer of adv_set by one (mod WAYS)
//     clear_all        return every pointer to 0
//     victim           chosen way index
//     victim_from_ptr  1 when the choice came from the pointer
module i_cache_victim_sel
  import i_cache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [clog2_min1(SETS)-1:0] lookup_set,
  input  logic [WAYS-1:0]             way_valid,
  input  logic                        adv_en,
  input  logic [clog2_min1(SETS)-1:0] adv_set,
  input  logic                        clear_all,
  output logic [clog2_min1(WAYS)-1:0] victim,
  output logic                        victim_from_ptr
);

  localparam int WW = clog2_min1(WAYS);
  localparam int SW = clog2_min1(SETS);

  logic [WW-1:0] rr_ptr_reg [SETS];

  // WAYS is a power of two, so the natural wrap of the counter is mod WAYS.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_rr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_ptr_reg[gi] <= '0;
      end else if (clear_all) begin
        rr_ptr_reg[gi] <= '0;
      end else if (adv_en && (adv_set == SW'(gi))) begin
        rr_ptr_reg[gi] <= rr_ptr_reg[gi] + 1'b1;
      end
    end
  end

  // Scan high to low so the last assignment is the lowest invalid way.
  always_comb begin
    victim          = rr_ptr_reg[lookup_set];
    victim_from_ptr = 1'b1;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        victim          = WW'(i);
        victim_from_ptr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/i_cache_assoc_control.sv
// i_cache_assoc_control
//   Control FSM of a WAYS-way set-associative instruction cache: hit
//   detection, multi-beat line refill, tag/valid commit, whole-cache flush
//   (also run automatically out of reset).
//   Ports:
//     cache_read/set_idx/hit_way/way_valid  lookup from the fetch datapath
//     flush                                 one-cycle invalidate request
//     mmem_status / mmem_r / mmem_beat      memory beat handshake
//     data_we/tag_we/v_we/v_wdata/arr_set   array write controls
//     ready, busy, flush_done               status to the datapath
module i_cache_assoc_control
  import i_cache_pkg::*;
#(
  parameter int WAYS       = DEF_WAYS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int SETS       = DEF_SETS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cache_read,
  input  logic [clog2_min1(SETS)-1:0]       set_idx,
  input  logic [WAYS-1:0]                   hit_way,
  input  logic [WAYS-1:0]                   way_valid,
  input  logic                              flush,
  input  logic                              mmem_status,
  output logic                              ready,
  output logic                              mmem_r,
  output logic [clog2_min1(LINE_WORDS)-1:0] mmem_beat,
  output logic [WAYS-1:0]                   data_we,
  output logic [WAYS-1:0]                   tag_we,
  output logic [WAYS-1:0]                   v_we,
  output logic                              v_wdata,
  output logic [clog2_min1(SETS)-1:0]       arr_set,
  output logic                              busy,
  output logic                              flush_done
);

  localparam int WW = clog2_min1(WAYS);
  localparam int BW = clog2_min1(LINE_WORDS);
  localparam int SW = clog2_min1(SETS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [SW-1:0] LAST_SET  = SW'(SETS - 1);

  icache_state_t state_reg, state_next;
  logic [BW-1:0] beat_reg;
  logic [SW-1:0] set_reg;
  logic [SW-1:0] flush_cnt_reg;
  logic [WW-1:0] victim_reg;
  logic          victim_ptr_reg;
  logic          flush_pend_reg;
  logic          flush_done_reg;

  logic [WW-1:0]   sel_victim;
  logic            sel_from_ptr;
  logic [WAYS-1:0] victim_oh;
  logic            miss, beat_fire, last_beat, flush_last;

  // flush outranks a lookup in IDLE, so a flush cycle is never a miss.
  assign miss       = (state_reg == ST_IDLE) && cache_read && !flush && (hit_way == '0);
  assign beat_fire  = (state_reg == ST_REFILL) && mmem_status;
  assign last_beat  = beat_fire && (beat_reg == LAST_BEAT);
  assign flush_last = (state_reg == ST_FLUSH) && (flush_cnt_reg == LAST_SET);
  assign victim_oh  = WAYS'(1) << victim_reg;

  i_cache_victim_sel #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_victim_sel (
    .clk             (clk),
    .rst_n           (rst_n),
    .lookup_set      (set_idx),
    .way_valid       (way_valid),
    .adv_en          ((state_reg == ST_COMMIT) && victim_ptr_reg),
    .adv_set         (set_reg),
    .clear_all       (flush_last),
    .victim          (sel_victim),
    .victim_from_ptr (sel_from_ptr)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_FLUSH;
      beat_reg       <= '0;
      set_reg        <= '0;
      flush_cnt_reg  <= '0;
      victim_reg     <= '0;
      victim_ptr_reg <= 1'b0;
      flush_pend_reg <= 1'b0;
      flush_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      // Registered so the pulse lands in the first IDLE cycle after the sweep.
      flush_done_reg <= flush_last;
      if (miss) begin
        set_reg        <= set_idx;
        victim_reg     <= sel_victim;
        victim_ptr_reg <= sel_from_ptr;
        beat_reg       <= '0;
      end
      if (beat_fire) begin
        beat_reg <= last_beat ? '0 : beat_reg + 1'b1;
      end
      // Counter sits at 0 outside FLUSH so every sweep starts at set 0.
      if (state_reg == ST_FLUSH) begin
        flush_cnt_reg <= flush_last ? '0 : flush_cnt_reg + 1'b1;
      end else begin
        flush_cnt_reg <= '0;
      end
      // COMMIT consumes the pending request; REFILL only collects it.
      if (state_reg == ST_COMMIT) begin
        flush_pend_reg <= 1'b0;
      end else if ((state_reg == ST_REFILL) && flush) begin
        flush_pend_reg <= 1'b1;
      end
    end
  end

  // Next-state logic. A flush arriving in the COMMIT cycle itself is honoured
  // immediately rather than being parked in the pending flag.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (flush)     state_next = ST_FLUSH;
        else if (miss) state_next = ST_REFILL;
      end
      ST_REFILL: if (last_beat) state_next = ST_COMMIT;
      ST_COMMIT: state_next = (flush_pend_reg || flush) ? ST_FLUSH : ST_IDLE;
      ST_FLUSH:  if (flush_last) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs. Everything is forced low while reset is asserted, even though
  // the state register already holds FLUSH.
  always_comb begin
    ready      = 1'b0;
    mmem_r     = 1'b0;
    mmem_beat  = beat_reg;
    data_we    = '0;
    tag_we     = '0;
    v_we       = '0;
    v_wdata    = 1'b0;
    arr_set    = set_reg;
    busy       = (state_reg != ST_IDLE);
    flush_done = flush_done_reg;
    case (state_reg)
      ST_IDLE:   ready = cache_read && !flush && (hit_way != '0);
      ST_REFILL: begin
        mmem_r = 1'b1;
        if (mmem_status) data_we = victim_oh;
      end
      ST_COMMIT: begin
        tag_we  = victim_oh;
        v_we    = victim_oh;
        v_wdata = 1'b1;
      end
      ST_FLUSH: begin
        arr_set = flush_cnt_reg;
        v_we    = '1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      ready      = 1'b0;
      mmem_r     = 1'b0;
      mmem_beat  = '0;
      data_we    = '0;
      tag_we     = '0;
      v_we       = '0;
      v_wdata    = 1'b0;
      arr_set    = '0;
      busy       = 1'b0;
      flush_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_i_cache_assoc_control.sv
// tb_i_cache_assoc_control
//   Self-checking bench. The bench plays the tag-compare logic: it keeps its
//   own picture of each set's lines (valid, tag) and round-robin pointer,
//   derives hit_way/way_valid from it, and predicts every controller output
//   transaction by transaction. Inputs change 1 time unit after the rising
//   edge; outputs are sampled on the falling edge.
module tb_i_cache_assoc_control;

  localparam int WAYS       = 2;
  localparam int LINE_WORDS = 4;
  localparam int SETS       = 16;
  localparam int SW         = 4;
  localparam int BW         = 2;
  localparam int REFILL_MAX = 200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cache_read = 1'b0;
  logic [SW-1:0]   set_idx = '0;
  logic [WAYS-1:0] hit_way = '0;
  logic [WAYS-1:0] way_valid = '0;
  logic            flush = 1'b0;
  logic            mmem_status = 1'b0;
  logic            ready, mmem_r, v_wdata, busy, flush_done;
  logic [BW-1:0]   mmem_beat;
  logic [WAYS-1:0] data_we, tag_we, v_we;
  logic [SW-1:0]   arr_set;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference picture of the cache.
  bit m_valid [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_rr    [SETS];
  int pat     [7] = '{1, 0, 0, 1, 1, 0, 1};

  always #5 clk = ~clk;

  i_cache_assoc_control #(
    .WAYS       (WAYS),
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cache_read  (cache_read),
    .set_idx     (set_idx),
    .hit_way     (hit_way),
    .way_valid   (way_valid),
    .flush       (flush),
    .mmem_status (mmem_status),
    .ready       (ready),
    .mmem_r      (mmem_r),
    .mmem_beat   (mmem_beat),
    .data_we     (data_we),
    .tag_we      (tag_we),
    .v_we        (v_we),
    .v_wdata     (v_wdata),
    .arr_set     (arr_set),
    .busy        (busy),
    .flush_done  (flush_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WAYS-1:0] model_hit(input int s, input int t);
    logic [WAYS-1:0] r = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [WAYS-1:0] model_valid(input int s);
    logic [WAYS-1:0] r = '0;
    for (int w = 0; w < WAYS; w++) r[w] = m_valid[s][w];
    return r;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered in the first FLUSH cycle (inputs may be driven now). Walks the
  // whole sweep, then the flush_done cycle and the cycle after it.
  task automatic expect_flush(input string ctx);
    for (int i = 0; i < SETS; i++) begin
      cache_read  = 1'b1;
      hit_way     = WAYS'($urandom);
      set_idx     = SW'($urandom);
      flush       = ($urandom_range(0, 7) == 0);
      mmem_status = 1'($urandom);
      @(negedge clk);
      check_eq({ctx, "_busy"},    busy, 1);
      check_eq({ctx, "_v_we"},    v_we, {WAYS{1'b1}});
      check_eq({ctx, "_v_wdata"}, v_wdata, 0);
      check_eq({ctx, "_arr_set"}, arr_set, i);
      check_eq({ctx, "_ready"},   ready, 0);
      check_eq({ctx, "_fdone"},   flush_done, 0);
      next_cycle();
    end
    cache_read = 1'b0;
    flush      = 1'b0;
    @(negedge clk);
    check_eq({ctx, "_end_busy"}, busy, 0);
    check_eq({ctx, "_end_fdone"}, flush_done, 1);
    next_cycle();
    @(negedge clk);
    check_eq({ctx, "_fdone_pulse"}, flush_done, 0);
    next_cycle();
    model_clear();
    $display("flush %s: %0d sets invalidated", ctx, SETS);
  endtask

  // One fetch request. mode: 0 beats every cycle, 1 random, 2 fixed pattern.
  // fb >= 0 pulses flush in the first refill cycle seen at that beat.
  task automatic do_req(input int s, input int t, input int mode, input int fb);
    logic [WAYS-1:0] hv, oh;
    int  v, beats, cyc;
    bit  from_ptr, st, fsent;
    hv          = model_hit(s, t);
    cache_read  = 1'b1;
    set_idx     = SW'(s);
    hit_way     = hv;
    way_valid   = model_valid(s);
    flush       = 1'b0;
    mmem_status = 1'($urandom);
    @(negedge clk);
    if (hv != '0) begin
      check_eq("hit_ready", ready, 1);
      check_eq("hit_busy", busy, 0);
      check_eq("hit_mmem_r", mmem_r, 0);
      next_cycle();
      cache_read = 1'b0;
      $display("req set=%0d tag=%0d hit way_vec=%b", s, t, hv);
      return;
    end
    check_eq("miss_ready", ready, 0);
    from_ptr = 1'b1;
    v        = m_rr[s];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_valid[s][w]) begin v = w; from_ptr = 1'b0; end
    oh    = '0;
    oh[v] = 1'b1;
    next_cycle();
    beats = 0;
    cyc   = 0;
    fsent = 1'b0;
    while (beats < LINE_WORDS && cyc < REFILL_MAX) begin
      st = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom) : (pat[cyc % 7] != 0);
      mmem_status = st;
      hit_way     = WAYS'($urandom);
      way_valid   = WAYS'($urandom);
      set_idx     = SW'($urandom);
      cache_read  = ($urandom_range(0, 3) != 0);
      flush       = (fb >= 0 && !fsent && beats == fb);
      if (flush) fsent = 1'b1;
      @(negedge clk);
      check_eq("refill_mmem_r", mmem_r, 1);
      check_eq("refill_busy", busy, 1);
      check_eq("refill_data_we", data_we, st ? oh : '0);
      check_eq("refill_beat", mmem_beat, beats);
      check_eq("refill_arr_set", arr_set, s);
      check_eq("refill_tag_we", tag_we, 0);
      check_eq("refill_v_we", v_we, 0);
      check_eq("refill_ready", ready, 0);
      if (st) beats++;
      cyc++;
      next_cycle();
      flush = 1'b0;
    end
    if (beats < LINE_WORDS) begin
      check_eq("refill_timeout_beats", beats, LINE_WORDS);
      return;
    end
    // COMMIT cycle.
    mmem_status = 1'($urandom);
    cache_read  = 1'($urandom);
    @(negedge clk);
    check_eq("commit_tag_we", tag_we, oh);
    check_eq("commit_v_we", v_we, oh);
    check_eq("commit_v_wdata", v_wdata, 1);
    check_eq("commit_mmem_r", mmem_r, 0);
    check_eq("commit_data_we", data_we, 0);
    check_eq("commit_arr_set", arr_set, s);
    check_eq("commit_busy", busy, 1);
    check_eq("commit_ready", ready, 0);
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = t;
    if (from_ptr) m_rr[s] = (m_rr[s] + 1) % WAYS;
    next_cycle();
    $display("req set=%0d tag=%0d miss victim=%0d (%s) refill_cycles=%0d%s",
             s, t, v, from_ptr ? "rr" : "invalid", cyc, fsent ? " flush_pending" : "");
    if (fsent) begin
      expect_flush("pend");
      return;
    end
    cache_read = 1'b1;
    set_idx    = SW'(s);
    hit_way    = model_hit(s, t);
    way_valid  = model_valid(s);
    @(negedge clk);
    check_eq("relookup_ready", ready, 1);
    check_eq("relookup_busy", busy, 0);
    next_cycle();
    cache_read = 1'b0;
  endtask

  // flush in IDLE, with a simultaneous lookup of (s, t).
  task automatic flush_idle(input int s, input int t);
    cache_read = 1'b1;
    set_idx    = SW'(s);
    hit_way    = model_hit(s, t);
    way_valid  = model_valid(s);
    flush      = 1'b1;
    @(negedge clk);
    check_eq("fidle_ready", ready, 0);
    check_eq("fidle_busy", busy, 0);
    next_cycle();
    flush = 1'b0;
    expect_flush("idle");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    // Outputs held low during reset regardless of inputs.
    cache_read  = 1'b1;
    hit_way     = 2'b01;
    way_valid   = 2'b11;
    flush       = 1'b1;
    mmem_status = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_v_we", v_we, 0);
    check_eq("rst_mmem_r", mmem_r, 0);
    check_eq("rst_fdone", flush_done, 0);
    check_eq("rst_arr_set", arr_set, 0);
    next_cycle();
    rst_n      = 1'b1;
    cache_read = 1'b0;
    flush      = 1'b0;
    hit_way    = '0;
    way_valid  = '0;
    expect_flush("rst");

    // Directed scenarios.
    do_req(3, 10, 0, -1);
    do_req(3, 11, 0, -1);
    do_req(3, 12, 0, -1);
    do_req(3, 13, 0, -1);
    do_req(3, 14, 0, -1);
    do_req(3, 14, 0, -1);
    do_req(5, 20, 2, -1);
    do_req(7, 30, 0, 1);
    do_req(2, 40, 0, -1);
    flush_idle(2, 40);
    do_req(3, 50, 0, -1);
    do_req(3, 51, 0, -1);
    do_req(3, 52, 0, -1);

    // Randomised traffic over a few sets so hits, full sets and evictions mix.
    for (int k = 0; k < 150; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        flush_idle($urandom_range(0, 3), $urandom_range(0, 3));
      end else if (r == 1) begin
        cache_read = 1'b0;
        set_idx    = SW'($urandom);
        @(negedge clk);
        check_eq("idle_ready", ready, 0);
        check_eq("idle_busy", busy, 0);
        next_cycle();
      end else begin
        do_req($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, LINE_WORDS - 1) : -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
